// File: rtl/snake_pkg.sv
// snake_pkg: state/direction encodings and helpers for the snake game controller.
// SNAKE_PAUSE_EN adds the PAUSE state and widens the state encoding to 3 bits.
package snake_pkg;

    localparam int BCD_W = 4;

`ifdef SNAKE_PAUSE_EN
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DIE   = 3'd3,
        ST_OVER  = 3'd4
    } state_t;
`else
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DIE  = 2'd2,
        ST_OVER = 2'd3
    } state_t;
`endif

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Opposite directions differ only in bit 0 of the encoding.
    function automatic logic is_reversal(input logic [1:0] req, input logic [1:0] cur);
        return (req ^ cur) == 2'b01;
    endfunction

    // Three-digit BCD increment that saturates at 999.
    function automatic logic [3*BCD_W-1:0] bcd_inc(input logic [3*BCD_W-1:0] v);
        logic [3*BCD_W-1:0] r;
        logic               c;
        r = v;
        c = 1'b1;
        if (v == 12'h999) return v;
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                c = r[i*BCD_W +: BCD_W] == 4'd9;
                r[i*BCD_W +: BCD_W] = c ? 4'd0 : r[i*BCD_W +: BCD_W] + 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: programmable-period counter; wrap is high during the last count of each period.
module snake_tick_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] period,
    output logic        wrap
);

    logic [31:0] count;

    // >= so that a period shortened below the current count wraps on the next cycle
    assign wrap = en && !clr && (count >= period - 32'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= wrap ? '0 : count + 32'd1;
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game FSM, step tick, direction arbitration and BCD score for the snake game.
// Define SNAKE_PAUSE_EN to add pause_btn and the PAUSE state.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned TICK_BASE     = 25_000_000,
    parameter int unsigned TICK_STEP     = 1_000_000,
    parameter int unsigned TICK_MIN      = 5_000_000,
    parameter int unsigned FLASH_PERIOD  = 12_500_000,
    parameter int unsigned FLASH_TOGGLES = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic               dir_valid,
    input  logic [1:0]         dir_req,
    input  logic               apple_eaten,
    input  logic               hit_wall,
    input  logic               hit_body,
`ifdef SNAKE_PAUSE_EN
    input  logic               pause_btn,
`endif
    output logic               move_tick,
    output logic [1:0]         dir,
    output logic [STATE_W-1:0] game_state,
    output logic               snake_show,
    output logic [11:0]        score
);

    state_t      state, state_nxt;
    logic [31:0] period, toggle_cnt;
    logic [1:0]  pend;
    logic        in_play, running, hit, step_wrap, step_fire, accept, flash_wrap, flash_last;

    assign in_play = state == ST_PLAY;
`ifdef SNAKE_PAUSE_EN
    assign running = in_play || state == ST_PAUSE;
`else
    assign running = in_play;
`endif
    assign hit        = in_play && (hit_wall || hit_body);
    assign step_fire  = step_wrap && !hit;
    assign accept     = in_play && dir_valid && !is_reversal(dir_req, dir);
    assign flash_last = flash_wrap && toggle_cnt == FLASH_TOGGLES - 1;
    assign game_state = state;

    snake_tick_gen u_step (
        .clk    (clk),
        .rst    (rst),
        .clr    (!running),
        .en     (in_play),
        .period (period),
        .wrap   (step_wrap)
    );

    snake_tick_gen u_flash (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != ST_DIE),
        .en     (state == ST_DIE),
        .period (FLASH_PERIOD),
        .wrap   (flash_wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_btn) state_nxt = ST_PLAY;
`ifdef SNAKE_PAUSE_EN
            ST_PLAY:  state_nxt = hit ? ST_DIE : pause_btn ? ST_PAUSE : ST_PLAY;
            ST_PAUSE: if (pause_btn) state_nxt = ST_PLAY;
`else
            ST_PLAY:  if (hit) state_nxt = ST_DIE;
`endif
            ST_DIE:   if (flash_last) state_nxt = ST_OVER;
            ST_OVER:  if (start_btn) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            move_tick  <= 1'b0;
            dir        <= DIR_RIGHT;
            pend       <= DIR_RIGHT;
            score      <= '0;
            snake_show <= 1'b1;
            period     <= TICK_BASE;
            toggle_cnt <= '0;
        end else begin
            move_tick <= step_fire;
            if (step_fire)
                dir <= pend;
            if (accept)
                pend <= dir_req;
            // Clearing on entry to IDLE means the score reads zero as soon as IDLE is shown.
            if (state_nxt == ST_IDLE) begin
                score  <= '0;
                period <= TICK_BASE;
            end else if (in_play && apple_eaten && !hit) begin
                score  <= bcd_inc(score);
                period <= (period >= TICK_MIN + TICK_STEP) ? period - TICK_STEP : TICK_MIN;
            end
            if (flash_wrap) begin
                toggle_cnt <= flash_last ? '0 : toggle_cnt + 32'd1;
                snake_show <= flash_last ? 1'b1 : !snake_show;
            end
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed vector table, hand sequences and a randomized game,
// all compared cycle by cycle against a behavioural reference model.
module tb_snake_game_ctrl;

    logic        clk = 1'b0, rst = 1'b1;
    logic        start_btn = 1'b0, dir_valid = 1'b0, apple_eaten = 1'b0, hit_wall = 1'b0, hit_body = 1'b0;
    logic [1:0]  dir_req = 2'd0;
    logic        move_tick, snake_show;
    logic [1:0]  dir, game_state;
    logic [11:0] score;
    int          checks = 0, errors = 0, cyc = 0;

    snake_game_ctrl #(
        .TICK_BASE(10), .TICK_STEP(2), .TICK_MIN(4), .FLASH_PERIOD(3), .FLASH_TOGGLES(4)
    ) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .dir_valid(dir_valid), .dir_req(dir_req),
        .apple_eaten(apple_eaten), .hit_wall(hit_wall), .hit_body(hit_body),
        .move_tick(move_tick), .dir(dir), .game_state(game_state), .snake_show(snake_show), .score(score)
    );

    always #5 clk = ~clk;

    // Reference model: decimal score, absolute elapsed counts, opposite-direction table.
    int         m_state, m_cnt, m_period, m_score, m_fcnt, m_tog;
    logic       m_tick, m_show;
    logic [1:0] m_dir, m_pend;
    logic [1:0] opposite [4] = '{2'd1, 2'd0, 2'd3, 2'd2};

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_period = 10; m_score = 0; m_fcnt = 0; m_tog = 0;
        m_tick = 1'b0; m_show = 1'b1; m_dir = 2'd3; m_pend = 2'd3;
    endtask

    task automatic model_update();
        logic       wrap_now, hit;
        logic [1:0] new_dir;
        hit = hit_wall || hit_body;
        m_tick = 1'b0;
        case (m_state)
            0: begin
                m_score = 0; m_period = 10; m_cnt = 0;
                if (start_btn) m_state = 1;
            end
            1: begin
                wrap_now = m_cnt >= m_period - 1;
                m_tick = wrap_now && !hit;
                new_dir = m_tick ? m_pend : m_dir;
                if (dir_valid && dir_req != opposite[m_dir]) m_pend = dir_req;
                m_dir = new_dir;
                if (hit) begin
                    m_state = 2; m_fcnt = 0; m_tog = 0;
                end else begin
                    if (apple_eaten) begin
                        m_score = (m_score < 999) ? m_score + 1 : 999;
                        m_period = (m_period - 2 > 4) ? m_period - 2 : 4;
                    end
                    m_cnt = wrap_now ? 0 : m_cnt + 1;
                end
            end
            2: begin
                m_fcnt++;
                if (m_fcnt == 3) begin
                    m_fcnt = 0;
                    m_tog++;
                    if (m_tog == 4) begin
                        m_state = 3; m_show = 1'b1; m_tog = 0;
                    end else
                        m_show = !m_show;
                end
            end
            default: if (start_btn) begin
                m_state = 0; m_score = 0; m_period = 10;
            end
        endcase
    endtask

    task automatic step(input logic s, input logic dv, input logic [1:0] dr,
                        input logic ap, input logic hw, input logic hb);
        start_btn = s; dir_valid = dv; dir_req = dr; apple_eaten = ap; hit_wall = hw; hit_body = hb;
        @(posedge clk);
        model_update();
        #1;
        cyc++;
        chk("model", 32'({game_state, move_tick, dir, snake_show, score}),
            32'({2'(m_state), m_tick, m_dir, m_show, to_bcd(m_score)}));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apple(input int n);
        repeat (n) step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    endtask

    // stim = {start, dir_valid, dir_req, apple, hit_body}; exp = {state, tick, dir, show, score}
    typedef struct {
        int          cyc;
        logic [5:0]  stim;
        logic [17:0] exp;
    } vec_t;
    vec_t vecs [$];

    initial begin
        vecs.push_back('{5,  6'b000000, {2'd0, 1'b0, 2'd3, 1'b1, 12'h000}});
        vecs.push_back('{6,  6'b100000, {2'd1, 1'b0, 2'd3, 1'b1, 12'h000}});
        vecs.push_back('{15, 6'b000000, {2'd1, 1'b0, 2'd3, 1'b1, 12'h000}});
        vecs.push_back('{16, 6'b000000, {2'd1, 1'b1, 2'd3, 1'b1, 12'h000}});
        vecs.push_back('{20, 6'b011000, {2'd1, 1'b0, 2'd3, 1'b1, 12'h000}});
        vecs.push_back('{26, 6'b000000, {2'd1, 1'b1, 2'd3, 1'b1, 12'h000}});
        vecs.push_back('{28, 6'b010000, {2'd1, 1'b0, 2'd3, 1'b1, 12'h000}});
        vecs.push_back('{30, 6'b011000, {2'd1, 1'b0, 2'd3, 1'b1, 12'h000}});
        vecs.push_back('{36, 6'b000000, {2'd1, 1'b1, 2'd0, 1'b1, 12'h000}});
        vecs.push_back('{37, 6'b000010, {2'd1, 1'b0, 2'd0, 1'b1, 12'h001}});
        vecs.push_back('{43, 6'b000000, {2'd1, 1'b0, 2'd0, 1'b1, 12'h001}});
        vecs.push_back('{44, 6'b000000, {2'd1, 1'b1, 2'd0, 1'b1, 12'h001}});
        vecs.push_back('{45, 6'b000010, {2'd1, 1'b0, 2'd0, 1'b1, 12'h002}});
        vecs.push_back('{50, 6'b000000, {2'd1, 1'b1, 2'd0, 1'b1, 12'h002}});
        vecs.push_back('{51, 6'b000010, {2'd1, 1'b0, 2'd0, 1'b1, 12'h003}});
        vecs.push_back('{54, 6'b000000, {2'd1, 1'b1, 2'd0, 1'b1, 12'h003}});
        vecs.push_back('{55, 6'b000010, {2'd1, 1'b0, 2'd0, 1'b1, 12'h004}});
        vecs.push_back('{58, 6'b000000, {2'd1, 1'b1, 2'd0, 1'b1, 12'h004}});
        vecs.push_back('{61, 6'b000000, {2'd1, 1'b0, 2'd0, 1'b1, 12'h004}});
        vecs.push_back('{62, 6'b000000, {2'd1, 1'b1, 2'd0, 1'b1, 12'h004}});
        vecs.push_back('{64, 6'b000011, {2'd2, 1'b0, 2'd0, 1'b1, 12'h004}});
        vecs.push_back('{66, 6'b000000, {2'd2, 1'b0, 2'd0, 1'b1, 12'h004}});
        vecs.push_back('{67, 6'b000000, {2'd2, 1'b0, 2'd0, 1'b0, 12'h004}});
        vecs.push_back('{70, 6'b000000, {2'd2, 1'b0, 2'd0, 1'b1, 12'h004}});
        vecs.push_back('{73, 6'b000000, {2'd2, 1'b0, 2'd0, 1'b0, 12'h004}});
        vecs.push_back('{75, 6'b000000, {2'd2, 1'b0, 2'd0, 1'b0, 12'h004}});
        vecs.push_back('{76, 6'b000000, {2'd3, 1'b0, 2'd0, 1'b1, 12'h004}});
        vecs.push_back('{80, 6'b100000, {2'd0, 1'b0, 2'd0, 1'b1, 12'h000}});
        vecs.push_back('{85, 6'b100000, {2'd1, 1'b0, 2'd0, 1'b1, 12'h000}});

        model_reset();
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(game_state), 32'd0);
        chk("reset_tick", 32'(move_tick), 32'd0);
        chk("reset_dir", 32'(dir), 32'd3);
        chk("reset_score", 32'(score), 32'h000);
        chk("reset_show", 32'(snake_show), 32'd1);
        rst = 1'b1;
        cyc = 0;

        foreach (vecs[i]) begin
            while (cyc < vecs[i].cyc - 1) idle(1);
            step(vecs[i].stim[5], vecs[i].stim[4], vecs[i].stim[3:2], vecs[i].stim[1], 1'b0, vecs[i].stim[0]);
            chk($sformatf("vec_c%0d", vecs[i].cyc), 32'({game_state, move_tick, dir, snake_show, score}),
                32'(vecs[i].exp));
        end

        apple(99);
        chk("score_099", 32'(score), 32'h099);
        apple(1);
        chk("score_100", 32'(score), 32'h100);
        apple(899);
        chk("score_999", 32'(score), 32'h999);
        apple(1);
        chk("score_sat", 32'(score), 32'h999);

        // Fresh game, steer up, eat 12 apples, then pull reset between clock edges.
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        idle(10);
        apple(12);
        chk("pre_reset_dir", 32'(dir), 32'd0);
        chk("pre_reset_score", 32'(score), 32'h012);
        #2 rst = 1'b0;
        #1;
        chk("async_state", 32'(game_state), 32'd0);
        chk("async_score", 32'(score), 32'h000);
        chk("async_dir", 32'(dir), 32'd3);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 4000; i++)
            step($urandom_range(15) == 0, $urandom_range(2) == 0, 2'($urandom),
                 $urandom_range(5) == 0, $urandom_range(199) == 0, $urandom_range(199) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Game-flow sequencer for the snake datapath and VGA display path.
- Runs the game state machine (idle, play, dying flash, game over) and generates the snake step tick, with a period that shortens as score rises.
- Arbitrates player direction requests: one turn per step, no reversal.
- Maintains the 3-digit BCD score that feeds the display reward field.

Parameters:
- TICK_BASE, 25_000_000: initial step period in clk cycles.
- TICK_STEP, 1_000_000: period decrement per apple eaten.
- TICK_MIN, 5_000_000: floor on the step period.
- FLASH_PERIOD, 12_500_000: clk cycles per flash toggle in DIE.
- FLASH_TOGGLES, 6: number of flash toggles before GAME_OVER.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- start_btn, input, 1: debounced single-cycle pulse.
- dir_valid, input, 1: single-cycle direction request strobe.
- dir_req, input, 2: requested direction (0 up, 1 down, 2 left, 3 right).
- apple_eaten, input, 1: pulse from the snake datapath.
- hit_wall, input, 1: collision flag from the snake datapath.
- hit_body, input, 1: collision flag from the snake datapath.
- move_tick, output, 1: single-cycle pulse that advances the snake one cell.
- dir, output, 2: committed direction.
- game_state, output, 2: 0 IDLE, 1 PLAY, 2 DIE, 3 OVER.
- snake_show, output, 1: display enable for the snake; low during flash-off phases.
- score, output, 12: three BCD digits, for the display reward field.

Behaviour:
- Reset (rst low, asynchronous) values: state IDLE, move_tick 0, dir 3 (right), pending direction 3, score 0x000, snake_show 1, period TICK_BASE, all counters 0.
- IDLE:
  - start_btn -> PLAY on next edge.
  - Tick counter cleared; score cleared to 0x000; period set to TICK_BASE.
- PLAY:
  - Tick counter increments every cycle.
  - When count == period-1: counter wraps to 0, move_tick pulses high for exactly one cycle, and dir takes the pending direction in that same cycle.
  - First move_tick arrives `period` cycles after entering PLAY.
- Direction arbitration:
  - dir_valid is accepted in PLAY only, and only if (dir_req ^ dir) != 2'b01; that condition is the reversal test against the committed dir.
  - An accepted request overwrites the pending direction; the last accepted request before a tick wins.
  - Rejected or out-of-PLAY requests are ignored.
  - Request coinciding with move_tick: the commit uses the old pending value, and the new request becomes pending for the next step.
- Scoring:
  - apple_eaten in PLAY: score += 1 in BCD with per-digit carry; 999 saturates at 999.
  - Period -= TICK_STEP, clamped at TICK_MIN.
  - A new period takes effect on the next counter wrap. If the current count already ≥ new period-1, the tick fires on the next cycle.
- Collision:
  - hit_wall or hit_body in PLAY -> DIE next edge; move_tick suppressed from that cycle.
  - Collision and apple_eaten in the same cycle: collision wins, score unchanged.
- DIE:
  - Flash counter counts FLASH_PERIOD cycles per toggle; snake_show inverts on each toggle.
  - After FLASH_TOGGLES toggles -> OVER with snake_show forced 1.
- OVER:
  - Score held.
  - start_btn -> IDLE (score clears there); a second start_btn then starts play.
- Inputs are ignored in states where they are not listed.
- Reset asserted mid-game returns immediately to the reset values.
- Counter widths: 32 bits unsigned; period arithmetic must not underflow (compare before subtracting).

Optional Feature:
- SNAKE_PAUSE_EN defined:
  - Adds input pause_btn (pulse) and state PAUSE, encoded 2 on a 3-bit game_state; DIE becomes 3 and OVER becomes 4.
  - pause_btn toggles PLAY <-> PAUSE.
  - In PAUSE the tick counter freezes, dir_valid is ignored, and collision/apple inputs are ignored.
  - Resuming continues from the frozen count.
- Undefined: no pause port, game_state is 2 bits, and the encodings are as listed above.

Decomposition:
- Package snake_pkg holds:
  - state encodings;
  - direction encodings (DIR_UP/DOWN/LEFT/RIGHT);
  - BCD digit width;
  - the reversal-check function.
- One sub-module, snake_tick_gen: programmable-period counter with clear, enable and period inputs, and a wrap pulse output. It is used for both the step tick and the flash timer.

Test Plan (bench uses TICK_BASE=10, TICK_STEP=2, TICK_MIN=4, FLASH_PERIOD=3, FLASH_TOGGLES=4):
- Start: rst low then high, start_btn at cycle 5 -> game_state=1 at cycle 6; first move_tick at cycle 16, then every 10 cycles.
- Direction arbitration, with dir=3 (right):
  - dir_req=2 (left) -> rejected; dir stays 3 after the next tick.
  - dir_req=0 then dir_req=2 before the same tick -> dir=0 after the tick, since left was rejected against committed right.
- Apples and score:
  - Four apple_eaten pulses -> period steps 8, 6, 4, 4 (clamped); tick spacing measured accordingly.
  - Score preset to 0x099, one apple_eaten -> 0x100.
  - Score at 0x999, one apple_eaten -> stays 0x999.
- apple_eaten and hit_body in the same cycle -> game_state=2, score unchanged, no further move_tick.
- DIE flash: snake_show toggles every 3 cycles, four times, then game_state=3 with snake_show=1. start_btn -> IDLE with score 0x000.
- Reset mid-PLAY with score 0x012 and dir=0 -> state 0, score 0x000, dir 3 asynchronously, without waiting for a clk edge.
